// File: rtl/mips_io_pkg.sv
// Shared definitions for the board I/O conditioning blocks.
// Holds default timing constants, legal parameter ranges, the per-bit edge
// encoding used by the debounce cells, and a helper that sizes debounce counters.
package mips_io_pkg;

   // 4 ms at the 5 kHz processor clock.
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 20;

   localparam int unsigned SYNC_STAGES_MIN     = 2;
   localparam int unsigned SYNC_STAGES_MAX     = 4;
   localparam int unsigned DEBOUNCE_CYCLES_MIN = 2;
   localparam int unsigned DEBOUNCE_CYCLES_MAX = 65535;

   // Registered edge indication of one cell; a single encoded state makes a
   // simultaneous rise and fall pulse impossible by construction.
   typedef enum logic [1:0] {
      EdgeNone = 2'b00,
      EdgeRise = 2'b01,
      EdgeFall = 2'b10
   } edge_e;

   // Counter width able to hold 0..cycles.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/debounce_cell.sv
// One switch bit: synchronizer chain, debounce counter, stable level flop and
// registered one-cycle edge pulses.
//   clk         processor clock, rising edge
//   rst_n       asynchronous active-low reset
//   raw_in      raw switch level, asynchronous to clk
//   stable_out  debounced level
//   rise_pulse  one-cycle pulse, first cycle stable_out shows a new 1
//   fall_pulse  one-cycle pulse, first cycle stable_out shows a new 0
//   accept      combinational strobe, high in the cycle a change is accepted
module debounce_cell
   import mips_io_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_MIN,
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_in,
   output logic stable_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic accept
);

   localparam int unsigned     CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   sync;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   edge_e                  pulse_q, pulse_d;

   // Plain shift chain, nothing between stages.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
   end

   assign sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      pulse_d  = EdgeNone;
      accept   = 1'b0;
      if (sync == stable_q) begin
         // Agreement (or a glitch ending) restarts the count.
         cnt_d = '0;
      end else if (cnt_q >= CNT_LAST) begin
         // Held long enough: take the new level; counter stops here, never wraps.
         stable_d = sync;
         cnt_d    = '0;
         accept   = 1'b1;
         pulse_d  = sync ? EdgeRise : EdgeFall;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         pulse_q  <= EdgeNone;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         pulse_q  <= pulse_d;
      end
   end

   assign stable_out = stable_q;
   assign rise_pulse = (pulse_q == EdgeRise);
   assign fall_pulse = (pulse_q == EdgeFall);

endmodule

// File: rtl/switch_debouncer.sv
// Switch bank input conditioning: per-bit synchronize + debounce, edge pulses,
// sticky write-one-to-clear event flags and a registered interrupt.
//   clk          processor clock, rising edge
//   rst_n        asynchronous active-low reset
//   raw_in       raw switch levels, asynchronous to clk
//   evt_clr      write-one-to-clear strobe for evt_pending
//   stable_out   debounced levels to the SoC general-purpose input
//   rise_pulse   one-cycle pulse per bit on an accepted 0->1 change
//   fall_pulse   one-cycle pulse per bit on an accepted 1->0 change
//   evt_pending  sticky per-bit change flag
//   irq          registered OR of evt_pending
module switch_debouncer
   import mips_io_pkg::*;
#(
   parameter int unsigned WIDTH           = 5,
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_MIN,
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] raw_in,
   input  logic [WIDTH-1:0] evt_clr,
   output logic [WIDTH-1:0] stable_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic [WIDTH-1:0] evt_pending,
   output logic             irq
);

   logic [WIDTH-1:0] accept;
   logic [WIDTH-1:0] evt_pending_q, evt_pending_d;
   logic             irq_q, irq_d;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      debounce_cell #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_cell (
         .clk        (clk),
         .rst_n      (rst_n),
         .raw_in     (raw_in[i]),
         .stable_out (stable_out[i]),
         .rise_pulse (rise_pulse[i]),
         .fall_pulse (fall_pulse[i]),
         .accept     (accept[i])
      );
   end

   // The flag is latched on the accept edge so it is visible together with the
   // pulse, and the pulse itself keeps setting it, so a clear landing in the
   // pulse cycle loses to the set.
   always_comb begin
      evt_pending_d = (evt_pending_q & ~evt_clr) | accept | rise_pulse | fall_pulse;
      irq_d         = |evt_pending_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_pending_q <= '0;
         irq_q         <= 1'b0;
      end else begin
         evt_pending_q <= evt_pending_d;
         irq_q         <= irq_d;
      end
   end

   assign evt_pending = evt_pending_q;
   assign irq         = irq_q;

endmodule

// File: tb/tb_switch_debouncer.sv
module tb_switch_debouncer;

   localparam int unsigned WIDTH = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] raw_in = '0;
   logic [WIDTH-1:0] evt_clr = '0;
   logic [WIDTH-1:0] stable_out, rise_pulse, fall_pulse, evt_pending;
   logic             irq;

   int n_pass  = 0;
   int n_total = 0;

   switch_debouncer #(
      .WIDTH           (WIDTH),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw_in      (raw_in),
      .evt_clr     (evt_clr),
      .stable_out  (stable_out),
      .rise_pulse  (rise_pulse),
      .fall_pulse  (fall_pulse),
      .evt_pending (evt_pending),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input logic [WIDTH-1:0] raw);
      rst_n   = 1'b0;
      raw_in  = raw;
      evt_clr = '0;
      tick(2);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      raw_in  = 5'b11111;
      evt_clr = '0;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         n_total++;
         if ({stable_out, rise_pulse, fall_pulse, evt_pending, irq} !== 21'd0)
            $display("FAIL reset_hold: got %b expected all zero",
                     {stable_out, rise_pulse, fall_pulse, evt_pending, irq});
         else n_pass++;
      end
      rst_n = 1'b1;
      tick(5);
      n_total++;
      if (stable_out !== 5'b00000)
         $display("FAIL reset_release_early: stable_out got %b expected 00000", stable_out);
      else n_pass++;
      tick(1);
      n_total++;
      if ({stable_out, rise_pulse, fall_pulse, evt_pending, irq} !== {5'b11111, 5'b11111, 5'b00000, 5'b11111, 1'b0})
         $display("FAIL reset_release_accept: got %b expected %b",
                  {stable_out, rise_pulse, fall_pulse, evt_pending, irq},
                  {5'b11111, 5'b11111, 5'b00000, 5'b11111, 1'b0});
      else n_pass++;
      tick(1);
      n_total++;
      if ({stable_out, rise_pulse, evt_pending, irq} !== {5'b11111, 5'b00000, 5'b11111, 1'b1})
         $display("FAIL reset_release_irq: got %b expected %b",
                  {stable_out, rise_pulse, evt_pending, irq},
                  {5'b11111, 5'b00000, 5'b11111, 1'b1});
      else n_pass++;
   endtask

   task automatic test_glitch();
      int bad;
      // Three cycles high is one short of acceptance.
      do_reset('0);
      raw_in[0] = 1'b1;
      tick(3);
      raw_in[0] = 1'b0;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         if ((stable_out | rise_pulse | fall_pulse | evt_pending) !== 5'b00000) bad++;
      end
      n_total++;
      if (bad !== 0) $display("FAIL glitch_3_rejected: got %0d bad cycles expected 0", bad);
      else n_pass++;
      // Four cycles high is exactly enough.
      do_reset('0);
      raw_in[0] = 1'b1;
      tick(4);
      raw_in[0] = 1'b0;
      tick(1);
      n_total++;
      if (stable_out !== 5'b00000)
         $display("FAIL glitch_4_early: stable_out got %b expected 00000", stable_out);
      else n_pass++;
      tick(1);
      n_total++;
      if ({stable_out, rise_pulse} !== {5'b00001, 5'b00001})
         $display("FAIL glitch_4_accept: got %b expected %b", {stable_out, rise_pulse},
                  {5'b00001, 5'b00001});
      else n_pass++;
      tick(4);
      n_total++;
      if ({stable_out, fall_pulse} !== {5'b00000, 5'b00001})
         $display("FAIL glitch_4_fall: got %b expected %b", {stable_out, fall_pulse},
                  {5'b00000, 5'b00001});
      else n_pass++;
   endtask

   task automatic test_clean_step();
      do_reset('0);
      raw_in[2] = 1'b1;
      tick(5);
      n_total++;
      if ({stable_out, rise_pulse} !== 10'd0)
         $display("FAIL step_rise_early: got %b expected 0", {stable_out, rise_pulse});
      else n_pass++;
      tick(1);
      n_total++;
      if ({stable_out, rise_pulse, fall_pulse} !== {5'b00100, 5'b00100, 5'b00000})
         $display("FAIL step_rise: got %b expected %b", {stable_out, rise_pulse, fall_pulse},
                  {5'b00100, 5'b00100, 5'b00000});
      else n_pass++;
      tick(1);
      n_total++;
      if ({stable_out, rise_pulse} !== {5'b00100, 5'b00000})
         $display("FAIL step_rise_width: got %b expected %b", {stable_out, rise_pulse},
                  {5'b00100, 5'b00000});
      else n_pass++;
      raw_in[2] = 1'b0;
      tick(5);
      n_total++;
      if ({stable_out, fall_pulse} !== {5'b00100, 5'b00000})
         $display("FAIL step_fall_early: got %b expected %b", {stable_out, fall_pulse},
                  {5'b00100, 5'b00000});
      else n_pass++;
      tick(1);
      n_total++;
      if ({stable_out, rise_pulse, fall_pulse} !== {5'b00000, 5'b00000, 5'b00100})
         $display("FAIL step_fall: got %b expected %b", {stable_out, rise_pulse, fall_pulse},
                  {5'b00000, 5'b00000, 5'b00100});
      else n_pass++;
      tick(1);
      n_total++;
      if (fall_pulse !== 5'b00000)
         $display("FAIL step_fall_width: fall_pulse got %b expected 00000", fall_pulse);
      else n_pass++;
   endtask

   // Runs straight after test_clean_step: bit 2 has a pending event.
   task automatic test_handshake();
      n_total++;
      if ({evt_pending, irq} !== {5'b00100, 1'b1})
         $display("FAIL hs_pending: got %b expected %b", {evt_pending, irq}, {5'b00100, 1'b1});
      else n_pass++;
      evt_clr = 5'b00100;
      tick(1);
      evt_clr = '0;
      n_total++;
      if ({evt_pending, irq} !== {5'b00000, 1'b1})
         $display("FAIL hs_clear: got %b expected %b", {evt_pending, irq}, {5'b00000, 1'b1});
      else n_pass++;
      tick(1);
      n_total++;
      if (irq !== 1'b0) $display("FAIL hs_irq_lag: irq got %b expected 0", irq);
      else n_pass++;
      evt_clr = 5'b00010;
      tick(1);
      evt_clr = '0;
      n_total++;
      if (evt_pending !== 5'b00000)
         $display("FAIL hs_clear_zero: evt_pending got %b expected 00000", evt_pending);
      else n_pass++;
      // Bit 3 rise, then clear it once the pulse is gone.
      raw_in[3] = 1'b1;
      tick(7);
      evt_clr = 5'b01000;
      tick(1);
      evt_clr = '0;
      n_total++;
      if (evt_pending !== 5'b00000)
         $display("FAIL hs_clear_bit3: evt_pending got %b expected 00000", evt_pending);
      else n_pass++;
      // Bit 3 fall with the clear held across the accept and pulse cycles.
      raw_in[3] = 1'b0;
      tick(5);
      evt_clr = 5'b01000;
      tick(1);
      n_total++;
      if ({fall_pulse, evt_pending} !== {5'b01000, 5'b01000})
         $display("FAIL hs_set_wins_accept: got %b expected %b", {fall_pulse, evt_pending},
                  {5'b01000, 5'b01000});
      else n_pass++;
      tick(1);
      n_total++;
      if (evt_pending !== 5'b01000)
         $display("FAIL hs_set_wins_pulse: evt_pending got %b expected 01000", evt_pending);
      else n_pass++;
      tick(1);
      evt_clr = '0;
      n_total++;
      if (evt_pending !== 5'b00000)
         $display("FAIL hs_clear_after: evt_pending got %b expected 00000", evt_pending);
      else n_pass++;
   endtask

   task automatic test_bounce();
      int pulses;
      do_reset('0);
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         raw_in[1] = ~raw_in[1];
         repeat (2) begin
            tick(1);
            pulses += int'(rise_pulse[1]) + int'(fall_pulse[1]);
         end
      end
      raw_in[1] = 1'b1;
      repeat (5) begin
         tick(1);
         pulses += int'(rise_pulse[1]) + int'(fall_pulse[1]);
      end
      n_total++;
      if ({pulses[7:0], stable_out[1]} !== 9'd0)
         $display("FAIL bounce_quiet: pulses %0d stable %b expected 0 and 0", pulses,
                  stable_out[1]);
      else n_pass++;
      tick(1);
      n_total++;
      if ({stable_out[1], rise_pulse[1]} !== 2'b11)
         $display("FAIL bounce_accept: got %b expected 11", {stable_out[1], rise_pulse[1]});
      else n_pass++;
      pulses = 0;
      repeat (8) begin
         tick(1);
         pulses += int'(rise_pulse[1]) + int'(fall_pulse[1]);
      end
      n_total++;
      if (pulses !== 0) $display("FAIL bounce_single: extra pulses got %0d expected 0", pulses);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset('0);
      raw_in = 5'b00001;
      tick(7);
      n_total++;
      if ({evt_pending, irq} !== {5'b00001, 1'b1})
         $display("FAIL ar_setup: got %b expected %b", {evt_pending, irq}, {5'b00001, 1'b1});
      else n_pass++;
      raw_in[4] = 1'b1;
      tick(3);
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({stable_out, rise_pulse, fall_pulse, evt_pending, irq} !== 21'd0)
         $display("FAIL ar_immediate: got %b expected all zero",
                  {stable_out, rise_pulse, fall_pulse, evt_pending, irq});
      else n_pass++;
      tick(1);
      rst_n = 1'b1;
      tick(5);
      n_total++;
      if (stable_out !== 5'b00000)
         $display("FAIL ar_restart_early: stable_out got %b expected 00000", stable_out);
      else n_pass++;
      tick(1);
      n_total++;
      if ({stable_out, rise_pulse, evt_pending} !== {5'b10001, 5'b10001, 5'b10001})
         $display("FAIL ar_restart_accept: got %b expected %b",
                  {stable_out, rise_pulse, evt_pending}, {5'b10001, 5'b10001, 5'b10001});
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_clean_step();
      test_handshake();
      test_bounce();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Input-conditioning block for the board-level switch bank. The display path drives data out to the board; this block brings board data in.
- Synchronizes raw, asynchronous switch levels into the processor clock domain, debounces each bit, and presents clean levels to the SoC general-purpose input.
- Produces one-cycle rise/fall pulses and a sticky per-bit event register with write-one-to-clear handshake, so firmware can poll or take an interrupt.

Parameters:
- WIDTH, 5, number of switch inputs conditioned.
- SYNC_STAGES, 2, flip-flop stages in each synchronizer chain (legal range 2..4).
- DEBOUNCE_CYCLES, 20, consecutive clk cycles a synchronized level must differ from the current stable level before it is accepted (legal range 2..65535).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each debounce counter (derived; not overridden).

Ports:
- clk  input  1  processor clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset; asserts immediately, and is released synchronously by the board-level reset logic.
- raw_in  input  WIDTH  raw switch levels, asynchronous to clk.
- evt_clr  input  WIDTH  write-one-to-clear strobe for evt_pending, valid for one cycle.
- stable_out  output  WIDTH  debounced level, feeds the SoC general-purpose input.
- rise_pulse  output  WIDTH  one-cycle pulse on an accepted 0->1 change.
- fall_pulse  output  WIDTH  one-cycle pulse on an accepted 1->0 change.
- evt_pending  output  WIDTH  sticky flag, set by any accepted change.
- irq  output  1  OR-reduction of evt_pending (registered).

Behaviour:
- Reset (rst_n low, asynchronous): clear all synchronizer flops, counters, stable_out, rise_pulse, fall_pulse, evt_pending and irq to 0.
- Synchronizer: raw_in[i] passes through SYNC_STAGES flops; the last stage is sync[i]. No logic sits between stages.
- Per-bit debounce, evaluated independently for each bit i:
  - sync[i] == stable_out[i]: cnt[i] <= 0.
  - sync[i] != stable_out[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - sync[i] != stable_out[i] and cnt[i] == DEBOUNCE_CYCLES-1: stable_out[i] <= sync[i] and cnt[i] <= 0. In the same cycle, rise_pulse[i] or fall_pulse[i] <= 1 according to the new level.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles restarts the count at 0 and produces no output change.
- Counter arithmetic is unsigned CNT_W and never wraps; it saturates at the accept point.
- Latency: a clean step on raw_in reaches stable_out exactly SYNC_STAGES + DEBOUNCE_CYCLES cycles after the first sampling edge. Pulses are registered and high in the first cycle stable_out shows the new value.
- Pulses are high for exactly one cycle, and a bit's rise and fall pulses are never high together.
- evt_pending[i]:
  - Set in the cycle rise_pulse[i] or fall_pulse[i] is high.
  - Cleared when evt_clr[i]=1.
  - Set and clear in the same cycle: set wins and the flag stays 1.
  - evt_clr on a bit already at 0 has no effect.
- irq is registered from evt_pending, so it lags evt_pending by one cycle.
- Bits are fully independent; simultaneous changes on several bits each complete on their own schedule.
- Reset mid-debounce discards the partial count. If the input is held high through the reset release, it is accepted after the full latency and produces a rise_pulse.

Decomposition:
- Shared package mips_io_pkg holds:
  - localparam DEFAULT_DEBOUNCE_CYCLES=20 (4 ms at the 5 kHz processor clock).
  - localparam SYNC_STAGES_MIN=2.
- Sub-module debounce_cell (one bit: synchronizer, counter, stable flop, edge pulses), instantiated WIDTH times with a generate loop.
- Event register and irq live in the top-level switch_debouncer.

Test Plan:
- Reset: hold rst_n=0 with raw_in=5'b11111 -> all outputs 0 and remain 0 during reset; after release with DEBOUNCE_CYCLES=4, SYNC_STAGES=2 -> stable_out=5'b11111 at cycle 6, rise_pulse=5'b11111 for one cycle, evt_pending=5'b11111, irq=1 at cycle 7.
- Glitch rejection: raw_in[0] high for 3 cycles, then low (DEBOUNCE_CYCLES=4) -> stable_out[0] stays 0, no pulse, evt_pending unchanged.
- Clean step and latency: raw_in[2] 0->1 and held -> stable_out[2]=1 exactly 6 cycles later, rise_pulse[2] one cycle wide; then 1->0 -> fall_pulse[2] after 6 cycles.
- Bounce: raw_in[1] toggles every 2 cycles for 20 cycles, then settles at 1 -> exactly one rise_pulse[1], 6 cycles after the last transition.
- Handshake: evt_pending=5'b00100, pulse evt_clr=5'b00100 -> evt_pending=0 next cycle, irq=0 one cycle later; evt_clr[3] in the same cycle as fall_pulse[3] -> evt_pending[3]=1.
- Async reset mid-operation: drop rst_n during cycle 3 of a bit-4 debounce -> outputs clear immediately; after release with the input still high -> full 6-cycle latency restarts and rise_pulse[4] fires.
